// File: rtl/tpu_host_driver.sv
// Purpose    : host-side job driver for the 2x2 systolic TPU; loads 4 weights + 4 inputs, collects 4 int16 results.
// Latency    : acceptance to res_valid = 17 cycles when done is seen in the first WAIT cycle (plus CAPTURE_SKEW).
// Backpressure: cmd_ready only in IDLE; results are held on res_* until res_valid && res_ready.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             job request; cmd_weights {w3,w2,w1,w0}, cmd_inputs {x3,x2,x1,x0}, cmd_transpose
//   load_en, host_indata            TPU byte-load strobe and byte (w0..w3 then x0..x3)
//   transpose                       TPU transpose control, held from acceptance until the next job
//   tpu_done, tpu_outdata           TPU completion flag and 8-byte result stream (c00 hi/lo .. c11 hi/lo)
//   res_valid/res_ready             result handshake; res_c00..res_c11 signed results, res_err on timeout
//   busy                            high whenever a job is in flight
module tpu_host_driver #(
    parameter int TIMEOUT      = 64,
    parameter int CAPTURE_SKEW = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_weights,
    input  logic [31:0] cmd_inputs,
    input  logic        cmd_transpose,
    output logic        load_en,
    output logic [7:0]  host_indata,
    output logic        transpose,
    input  logic        tpu_done,
    input  logic [7:0]  tpu_outdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_c00,
    output logic [15:0] res_c01,
    output logic [15:0] res_c10,
    output logic [15:0] res_c11,
    output logic        res_err,
    output logic        busy
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SKW_W = (CAPTURE_SKEW > 1) ? $clog2(CAPTURE_SKEW) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT    = 3'd2,
        SKEW    = 3'd3,
        CAPTURE = 3'd4,
        RESULT  = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [63:0]        load_q;       // {x3,x2,x1,x0,w3,w2,w1,w0}: byte n is sent in LOAD cycle n
    logic [63:0]        res_q;        // {c00,c01,c10,c11}: stream byte k lands at bits [63-8k -: 8]
    logic [2:0]         byte_cnt_q;   // shared by LOAD and capture; wraps 7->0 on leaving LOAD
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [SKW_W-1:0]   skw_cnt_q;
    logic               err_q;
    logic               transpose_q;

    logic               accept;
    logic               capture;
    logic               timeout;
    logic               handshake;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and datapath strobes
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        handshake = 1'b0;
        cmd_ready = 1'b0;
        load_en   = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                if (byte_cnt_q == 3'd7) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // done wins over the watchdog when both land on the same cycle
                if (tpu_done) begin
                    if (CAPTURE_SKEW == 0) begin
                        capture = 1'b1;          // this cycle is capture cycle 0
                        state_d = CAPTURE;
                    end else begin
                        state_d = SKEW;
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = RESULT;
                end
            end
            SKEW: begin
                // last skew cycle samples byte 0, so byte 0 is CAPTURE_SKEW cycles after done
                if (skw_cnt_q == SKW_W'(CAPTURE_SKEW - 1)) begin
                    capture = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                if (byte_cnt_q == 3'd7) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q      <= '0;
            res_q       <= '0;
            byte_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            skw_cnt_q   <= '0;
            err_q       <= 1'b0;
            transpose_q <= 1'b0;
        end else begin
            if (accept) begin
                load_q      <= {cmd_inputs, cmd_weights};
                transpose_q <= cmd_transpose;
                res_q       <= '0;
                byte_cnt_q  <= '0;
            end

            if (load_en || capture) begin
                byte_cnt_q <= byte_cnt_q + 3'd1;
            end

            if (state_q == LOAD) begin
                tmo_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (state_q == WAIT) begin
                skw_cnt_q <= '0;
            end else if (state_q == SKEW) begin
                skw_cnt_q <= skw_cnt_q + 1'b1;
            end

            // ~byte_cnt_q == 7 - byte_cnt_q: byte 0 is the high byte of c00
            if (capture) begin
                res_q[{~byte_cnt_q, 3'b000} +: 8] <= tpu_outdata;
            end

            if (timeout) begin
                res_q <= '0;
                err_q <= 1'b1;
            end

            if (handshake) begin
                err_q <= 1'b0;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign host_indata = load_en ? load_q[{byte_cnt_q, 3'b000} +: 8] : 8'h00;
    assign transpose   = transpose_q;
    assign res_err     = err_q;
    assign res_c00     = res_q[63:48];
    assign res_c01     = res_q[47:32];
    assign res_c10     = res_q[31:16];
    assign res_c11     = res_q[15:0];

endmodule

// File: tb/tb_tpu_host_driver.sv
// Purpose    : self-checking bench for tpu_host_driver, two instances (no skew and CAPTURE_SKEW=2) in lockstep.
// Latency    : checks every output on every falling edge against a cycle-indexed job model.
// Backpressure: exercises held results, stray commands while busy, and ready-before-valid.
module tb_tpu_host_driver;

    localparam int TMO   = 64;
    localparam int SKEW1 = 2;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [31:0] cmd_weights;
    logic [31:0] cmd_inputs;
    logic        cmd_transpose;
    logic        tpu_done;
    logic [7:0]  tpu_outdata [2];
    logic        res_ready   [2];
    logic        cmd_ready   [2];
    logic        load_en     [2];
    logic [7:0]  host_indata [2];
    logic        transpose   [2];
    logic        res_valid   [2];
    logic [15:0] res_c00     [2];
    logic [15:0] res_c01     [2];
    logic [15:0] res_c10     [2];
    logic [15:0] res_c11     [2];
    logic        res_err     [2];
    logic        busy        [2];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tpu_host_driver #(
            .TIMEOUT      (TMO),
            .CAPTURE_SKEW ((g == 0) ? 0 : SKEW1)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .cmd_valid     (cmd_valid),
            .cmd_ready     (cmd_ready[g]),
            .cmd_weights   (cmd_weights),
            .cmd_inputs    (cmd_inputs),
            .cmd_transpose (cmd_transpose),
            .load_en       (load_en[g]),
            .host_indata   (host_indata[g]),
            .transpose     (transpose[g]),
            .tpu_done      (tpu_done),
            .tpu_outdata   (tpu_outdata[g]),
            .res_valid     (res_valid[g]),
            .res_ready     (res_ready[g]),
            .res_c00       (res_c00[g]),
            .res_c01       (res_c01[g]),
            .res_c10       (res_c10[g]),
            .res_c11       (res_c11[g]),
            .res_err       (res_err[g]),
            .busy          (busy[g])
        );
    end

    // One job: command, TPU behaviour, consumer behaviour, and the expected outcome.
    typedef struct {
        logic [31:0] w;
        logic [31:0] x;
        logic        tr;
        logic [63:0] ob;     // TPU result stream, byte 0 in [63:56]
        int          d;      // WAIT cycles with done low before done is sampled high
        int          rd;     // RESULT cycles with ready low; -1 = ready held high throughout
        logic        pulse;  // drive a stray command while the job is in RESULT
        logic [63:0] eres;   // expected {c00,c01,c10,c11}
        logic        eerr;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %h, required %h", name, i, $time, act, exp);
        end
    endtask

    // Reference: a result word is the big-endian pair of consecutive stream bytes;
    // a job whose done never arrives within TMO WAIT cycles reports an error with zero results.
    function automatic vec_t ref_model(input vec_t v);
        vec_t        r;
        logic [7:0]  b;
        logic [15:0] c [4];
        r = v;
        for (int j = 0; j < 4; j++) c[j] = 16'h0;
        r.eerr = (v.d >= TMO);
        if (!r.eerr) begin
            for (int k = 0; k < 8; k++) begin
                b = v.ob[63 - 8 * k -: 8];
                if (k % 2 == 0) c[k / 2] = c[k / 2] + {b, 8'h00};
                else            c[k / 2] = c[k / 2] + {8'h00, b};
            end
        end
        r.eres = {c[0], c[1], c[2], c[3]};
        return r;
    endfunction

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_load_en"}, i, 64'(load_en[i]), 64'(0));
            chk({tag, "_host"}, i, 64'(host_indata[i]), 64'(0));
            chk({tag, "_transpose"}, i, 64'(transpose[i]), 64'(0));
            chk({tag, "_res_valid"}, i, 64'(res_valid[i]), 64'(0));
            chk({tag, "_res_err"}, i, 64'(res_err[i]), 64'(0));
            chk({tag, "_res"}, i, {res_c00[i], res_c01[i], res_c10[i], res_c11[i]}, 64'(0));
            chk({tag, "_busy"}, i, 64'(busy[i]), 64'(0));
        end
    endtask

    // Called on a falling edge with both instances idle; returns on a falling edge with both idle.
    // Falling edge n is the one after the n-th rising edge following acceptance.
    task automatic run_job(input vec_t v);
        int   r_at [2];
        int   h_at [2];
        int   sk   [2];
        int   last;
        int   j;
        logic vld;
        sk[0] = 0;
        sk[1] = SKEW1;
        for (int i = 0; i < 2; i++) begin
            r_at[i] = (v.d >= TMO) ? 8 + TMO : 16 + v.d + sk[i];
            h_at[i] = r_at[i] + ((v.rd < 0) ? 0 : v.rd);
        end
        last = ((h_at[0] > h_at[1]) ? h_at[0] : h_at[1]) + 1;

        for (int i = 0; i < 2; i++) begin
            chk("cmd_ready_idle", i, 64'(cmd_ready[i]), 64'(1));
            res_ready[i] = (v.rd < 0);
        end
        cmd_valid     = 1'b1;
        cmd_weights   = v.w;
        cmd_inputs    = v.x;
        cmd_transpose = v.tr;
        tpu_done      = 1'b0;

        for (int n = 0; n <= last; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                vld = (n >= r_at[i]) && (n <= h_at[i]);
                chk("load_en", i, 64'(load_en[i]), 64'(n <= 7));
                chk("host_indata", i, 64'(host_indata[i]),
                    (n <= 7) ? (({v.x, v.w} >> (8 * n)) & 64'hFF) : 64'(0));
                chk("busy", i, 64'(busy[i]), 64'(n <= h_at[i]));
                chk("cmd_ready", i, 64'(cmd_ready[i]), 64'(n > h_at[i]));
                chk("transpose", i, 64'(transpose[i]), 64'(v.tr));
                chk("res_valid", i, 64'(res_valid[i]), 64'(vld));
                if (vld) begin
                    chk("results", i, {res_c00[i], res_c01[i], res_c10[i], res_c11[i]}, v.eres);
                    chk("res_err", i, 64'(res_err[i]), 64'(v.eerr));
                end
                if (n > h_at[i]) begin
                    chk("res_err_clear", i, 64'(res_err[i]), 64'(0));
                end
            end

            // Stimulus for the next rising edge
            cmd_valid = v.pulse && (n >= r_at[0]) && (n < h_at[0]) && (n < h_at[1]);
            if (cmd_valid) begin
                cmd_weights   = $urandom;
                cmd_inputs    = $urandom;
                cmd_transpose = ~v.tr;
            end
            if (v.d < TMO && n == 8 + v.d) tpu_done = 1'b1;
            else if (n > 8 + v.d)          tpu_done = 1'($urandom);
            else                           tpu_done = 1'b0;
            for (int i = 0; i < 2; i++) begin
                j = n - (8 + v.d + sk[i]);
                tpu_outdata[i] = (j >= 0 && j < 8) ? v.ob[63 - 8 * j -: 8] : 8'($urandom);
                res_ready[i]   = (v.rd < 0) || (n == r_at[i] + v.rd);
            end
        end
        cmd_valid = 1'b0;
        tpu_done  = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   t;

        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_weights    = 32'h0;
        cmd_inputs     = 32'h0;
        cmd_transpose  = 1'b0;
        tpu_done       = 1'b0;
        tpu_outdata[0] = 8'h0;
        tpu_outdata[1] = 8'h0;
        res_ready[0]   = 1'b0;
        res_ready[1]   = 1'b0;

        //             w             x             tr    ob                      d        rd  pulse eres                    eerr
        tbl[0] = '{32'h04030201, 32'h08070605, 1'b0, 64'h0123456789ABCDEF, 2,       0,  1'b0, 64'h0123456789ABCDEF, 1'b0};
        tbl[1] = '{32'hDEADBEEF, 32'h80FF7F01, 1'b0, 64'h1122334455667788, 0,       10, 1'b1, 64'h1122334455667788, 1'b0};
        tbl[2] = '{32'h11223344, 32'h55667788, 1'b1, 64'hA5A5A5A5A5A5A5A5, TMO,     1,  1'b1, 64'h0,                1'b1};
        tbl[3] = '{32'h9ABCDEF0, 32'h0F0F0F0F, 1'b0, 64'h0F1E2D3C4B5A6978, TMO - 1, 2,  1'b0, 64'h0F1E2D3C4B5A6978, 1'b0};
        tbl[4] = '{32'h7F80FF01, 32'h00FF8001, 1'b1, 64'hFF8000017FFF8000, 0,       -1, 1'b0, 64'hFF8000017FFF8000, 1'b0};
        tbl[5] = '{32'h01020304, 32'hF0E0D0C0, 1'b1, 64'h80007FFF0001FF80, 5,       3,  1'b1, 64'h80007FFF0001FF80, 1'b0};
        tbl[6] = '{32'hCAFEF00D, 32'h12345678, 1'b1, 64'h00FF7F8001FE8081, 1,       0,  1'b0, 64'h00FF7F8001FE8081, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        for (int k = 0; k < 6; k++) run_job(tbl[k]);

        // Reset after three load bytes: outputs must drop without a clock edge.
        cmd_weights   = 32'hCAFEF00D;
        cmd_inputs    = 32'h12345678;
        cmd_transpose = 1'b1;
        cmd_valid     = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midload_byte2", 0, 64'(host_indata[0]), 64'hFE);
        chk("midload_load_en", 0, 64'(load_en[0]), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_abort");
        run_job(tbl[6]);

        // Randomised jobs against the reference model
        for (int k = 0; k < 24; k++) begin
            v.w  = $urandom;
            v.x  = $urandom;
            v.tr = 1'($urandom);
            v.ob = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) v.d = int'($urandom_range(TMO - 2, TMO + 1));
            else                           v.d = int'($urandom_range(0, 6));
            t        = int'($urandom_range(0, 4));
            v.rd     = t - 1;
            v.pulse  = 1'($urandom);
            v.eres   = 64'h0;
            v.eerr   = 1'b0;
            run_job(ref_model(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/tpu_host_driver.md
Name: tpu_host_driver

Overview:
- Host-side counterpart of the 2x2 systolic TPU control unit.
- Accepts one matmul job as a command: four int8 weights, four int8 inputs and a transpose flag.
- Serialises the job into the TPU byte-load interface (load_en plus host_indata, 8 bytes).
- Waits for the TPU done flag, deserialises the 8-byte result stream into four signed 16-bit results, and returns them on a valid/ready result port.

Parameters:
- TIMEOUT, default 64: maximum cycles in WAIT before the job is aborted with an error.
- CAPTURE_SKEW, default 0: cycles between the first sampled done=1 and the first captured result byte.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_weights  in  32  w0=[7:0], w1=[15:8], w2=[23:16], w3=[31:24].
- cmd_inputs  in  32  x0=[7:0] through x3=[31:24].
- cmd_transpose  in  1  transpose flag for this job.
- load_en  out  1  TPU byte-load strobe.
- host_indata  out  8  TPU load byte.
- transpose  out  1  TPU transpose control, held for the whole job.
- tpu_done  in  1  TPU done flag.
- tpu_outdata  in  8  TPU result byte stream.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_c00, res_c01, res_c10, res_c11  out  16 each  signed results.
- res_err  out  1  job timed out; results forced to 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - State is IDLE.
  - load_en=0, host_indata=0, transpose=0, res_valid=0, res_err=0, all res_c*=0, busy=0, cmd_ready=1 once out of reset.
  - Reset mid-job aborts it immediately; no partial result is ever presented.
- States: IDLE, LOAD, WAIT, SKEW, CAPTURE, RESULT.
- IDLE:
  - cmd_valid&&cmd_ready latches weights, inputs and transpose, clears the byte counter, and moves to LOAD.
  - The transpose output updates in the cycle after acceptance.
- LOAD (exactly 8 cycles):
  - load_en=1 every cycle.
  - host_indata order is w0,w1,w2,w3,x0,x1,x2,x3, one byte per cycle.
  - The first byte appears the cycle after acceptance.
  - After byte 7, go to WAIT and reset the timeout counter.
- WAIT:
  - load_en=0, host_indata=0.
  - tpu_done=1 goes to SKEW if CAPTURE_SKEW>0, otherwise straight to CAPTURE. That same cycle is capture cycle 0 when the skew is 0.
  - If the counter reaches TIMEOUT-1 without done, go to RESULT with res_err=1 and all results 0.
- SKEW: counts CAPTURE_SKEW cycles, then goes to CAPTURE.
- CAPTURE (8 consecutive cycles, tpu_done not re-checked):
  - Byte k of tpu_outdata is stored as: k0=c00[15:8], k1=c00[7:0], k2=c01[15:8], k3=c01[7:0], k4=c10[15:8], k5=c10[7:0], k6=c11[15:8], k7=c11[7:0].
  - After k7, go to RESULT.
- RESULT:
  - res_valid=1 and results are held stable until res_valid&&res_ready.
  - On that handshake, go to IDLE. res_valid drops the next cycle and res_err clears.
  - If res_ready is already high on entry, the result leaves after 1 cycle.
- cmd_valid outside IDLE is ignored; the command is not latched and cmd_ready=0.
- Latency with CAPTURE_SKEW=0 and done seen at the first WAIT cycle: acceptance to res_valid is 1 + 8 + 8 = 17 cycles.
- No arithmetic is done on the results: bytes are concatenated and the sign is carried as-is from the high byte.

Test Plan:
- Basic job:
  - Stimulus: weights=0x04030201, inputs=0x08070605, transpose=0. The TPU model raises done 3 cycles after the last load and streams 01 23 45 67 89 AB CD EF.
  - Required: host_indata sequence 01 02 03 04 05 06 07 08, each with load_en=1; res_c00=0x0123, res_c01=0x4567, res_c10=0x89AB, res_c11=0xCDEF; res_err=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles in RESULT; pulse cmd_valid during that window.
  - Required: results stay stable, cmd_ready=0, and the command is not accepted.
  - Then raise res_ready: res_valid falls the next cycle, and the next cmd_valid is accepted in IDLE.
- Timeout:
  - Stimulus: tpu_done never asserts.
  - Required: res_valid=1 with res_err=1 and all results 0, exactly TIMEOUT cycles after entering WAIT.
- Skew:
  - Stimulus: CAPTURE_SKEW=2.
  - Required: the first captured byte is the tpu_outdata value 2 cycles after done was first sampled.
- Reset mid-LOAD:
  - Stimulus: assert rst_n=0 after 3 bytes.
  - Required: load_en=0 and busy=0 asynchronously, with no clock edge needed.
  - A fresh job then completes with correct results.
- Transpose and sign:
  - Stimulus: transpose=1 with result bytes FF 80 00 01 7F FF 80 00.
  - Required: the transpose output is high through LOAD/WAIT/CAPTURE; res_c00=0xFF80 (-128), res_c01=0x0001, res_c10=0x7FFF, res_c11=0x8000.
